// File: rtl/modn_down_ctr.sv
// Loadable mod-N down counter with IDLE/RUN/DONE control FSM.
// Counts N-1 down to 0, pulses tc, then reloads (mode=1) or stops in DONE (mode=0).
module modn_down_ctr #(
    parameter int N     = 10,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(N - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             tc_nxt;
    logic [WIDTH-1:0] load_sat;

    assign load_sat = (load_val > MAX_CNT) ? MAX_CNT : load_val;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out   <= MAX_CNT;
            tc    <= 1'b0;
        end else begin
            state <= state_nxt;
            out   <= out_nxt;
            tc    <= tc_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        out_nxt   = out;
        tc_nxt    = 1'b0;
        if (load) begin
            out_nxt = load_sat;
            if (state == DONE) state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state_nxt = RUN;
                end
                RUN: begin
                    if (en) begin
                        if (out == '0) begin
                            tc_nxt = 1'b1;
                            if (mode) out_nxt = MAX_CNT;
                            else      state_nxt = DONE;
                        end else begin
                            out_nxt = out - WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        out_nxt   = MAX_CNT;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_modn_down_ctr.sv
// Scoreboard bench for modn_down_ctr: a reference model predicts each edge,
// expectations are queued on drive and compared one time unit after the edge.
module tb_modn_down_ctr;

    localparam int N = 10;
    localparam int W = 4;

    logic         clk;
    logic         rst, en, start, load, mode;
    logic [W-1:0] load_val;
    logic [W-1:0] out;
    logic         tc, busy, done;

    modn_down_ctr #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .load(load),
        .load_val(load_val), .mode(mode), .out(out), .tc(tc),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int out;
        int tc;
        int busy;
        int done;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    tc_seen  = 0;
    string phase    = "init";

    // reference model: 0=IDLE, 1=RUN, 2=DONE
    int m_state = 0;
    int m_out   = N - 1;
    int m_tc    = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s/%s: got %0d, expected %0d (t=%0t)", phase, tag, act, exp, $time);
    endtask

    task automatic model(input logic r, e, s, l, input int lv, input logic m);
        if (r) begin
            m_state = 0; m_out = N - 1; m_tc = 0;
        end else if (l) begin
            m_out = (lv > N - 1) ? N - 1 : lv;
            m_tc  = 0;
            if (m_state == 2) m_state = 0;
        end else if (s && m_state == 0) begin
            m_state = 1; m_tc = 0;
        end else if (s && m_state == 2) begin
            m_state = 1; m_out = N - 1; m_tc = 0;
        end else if (m_state == 1 && e) begin
            if (m_out == 0) begin
                m_tc = 1;
                if (m) m_out = N - 1;
                else   m_state = 2;
            end else begin
                m_out = m_out - 1;
                m_tc  = 0;
            end
        end else begin
            m_tc = 0;
        end
    endtask

    task automatic step(input logic r, e, s, l, input logic [W-1:0] lv, input logic m);
        exp_t x;
        rst = r; en = e; start = s; load = l; load_val = lv; mode = m;
        model(r, e, s, l, int'(lv), m);
        sb.push_back('{out: m_out, tc: m_tc, busy: int'(m_state == 1), done: int'(m_state == 2)});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            x = sb.pop_front();
            check("out",  int'(out),  x.out);
            check("tc",   int'(tc),   x.tc);
            check("busy", int'(busy), x.busy);
            check("done", int'(done), x.done);
        end
        if (tc) tc_seen++;
    endtask

    task automatic run(input int n, input logic e, input logic m);
        for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 1'b0, '0, m);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int tc_base;
        rst = 1'b1; en = 1'b0; start = 1'b0; load = 1'b0; load_val = '0; mode = 1'b0;

        phase = "reset";
        do_reset();
        do_reset();

        phase = "reset_mid";
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        run(4, 1'b1, 1'b0);
        check("mid_out", int'(out), 5);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);

        phase = "autoreload";
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        tc_base = tc_seen;
        run(30, 1'b1, 1'b1);
        check("tc_count", tc_seen - tc_base, 3);

        phase = "oneshot";
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        run(10, 1'b1, 1'b0);
        run(5, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        run(11, 1'b1, 1'b0);

        phase = "en_gate";
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 22; i++) step(1'b0, (i % 2 == 0), 1'b0, 1'b0, '0, 1'b0);

        phase = "load_run";
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        run(2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0);
        run(5, 1'b1, 1'b0);

        phase = "load_sat";
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0);
        run(3, 1'b1, 1'b0);

        phase = "load_start_idle";
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd4, 1'b0);
        run(3, 1'b1, 1'b0);

        phase = "load_done";
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        run(10, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
        run(4, 1'b1, 1'b0);

        phase = "random";
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                 W'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
        end

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/modn_down_ctr.md
Name: modN_down_ctr

Overview:
Loadable mod-N down counter with a run/done control FSM. It counts the other way to the team's mod-N up counter: from N-1 down to 0, then either wraps back to N-1 or stops. It serves as a timeout and interval generator beside the existing counters. Terminal count is flagged with a one-cycle pulse. It supports one-shot and auto-reload modes.

Parameters:
N, 10, modulus; count range is 0..N-1; N >= 2
WIDTH, 4, counter width; must satisfy 2^WIDTH >= N

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  count enable; counting happens only in RUN with en=1
start  input  1  single-cycle request to begin or re-arm counting
load  input  1  synchronous load of load_val into out
load_val  input  WIDTH  value to load; saturated to N-1 if greater than N-1
mode  input  1  0 = one-shot, 1 = auto-reload; sampled every cycle
out  output  WIDTH  current count, registered
tc  output  1  terminal-count pulse, registered, 1 cycle wide
busy  output  1  high while FSM is in RUN
done  output  1  high while FSM is in DONE (one-shot expired)

Behaviour:
- Reset, synchronous, active-high: clk and rst fixed as above. rst=1 at an edge gives:
  - state=IDLE, out=N-1, tc=0, busy=0, done=0.
  - rst overrides all other inputs, including in mid-count.
- FSM states: IDLE, RUN, DONE. busy = (state==RUN) and done = (state==DONE), both registered with the state.
- Priority per edge: rst > load > start > count.
- load=1, any state:
  - out <= min(load_val, N-1), tc <= 0.
  - IDLE stays IDLE; RUN stays RUN, and no decrement happens that cycle.
  - DONE goes to IDLE, so done clears.
  - A start in the same cycle is ignored.
- start=1, load=0:
  - IDLE: go to RUN, out unchanged.
  - DONE: out <= N-1, go to RUN.
  - RUN: ignored.
- RUN, en=0: out holds, tc <= 0.
- RUN, en=1, out != 0: out <= out-1, tc <= 0.
- RUN, en=1, out == 0: tc <= 1 for exactly one cycle, then:
  - mode=1: out <= N-1, stay in RUN.
  - mode=0: out stays 0, go to DONE.
- tc is 0 in every cycle not listed above.
- Timing: start in IDLE with out=N-1 and en held high:
  - out=N-1 at edge k (RUN entry).
  - out=0 at edge k+N-1.
  - tc=1 at edge k+N.
  - Auto-reload: tc repeats every N cycles thereafter.
- Arithmetic:
  - Decrement is never applied at 0, so there is no underflow.
  - out never exceeds N-1 under any input sequence.
  - All of this holds when N is not a power of two.
- IDLE and DONE: en has no effect and out holds.

Test Plan:
- Reset mid-count: N=10. Start, run 4 cycles (out=5), then rst=1 for 1 cycle -> out=9, tc=0, busy=0, done=0 on the next edge.
- Auto-reload: mode=1, en=1, start at edge k -> out sequence 9,8,...,0,9,...; tc=1 at edges k+10, k+20, k+30 only; busy stays 1.
- One-shot: mode=0, start -> tc=1 at edge k+10, done=1 and busy=0 from k+10, out stays 0 for 5 further cycles. A second start -> out=9, RUN, tc again 10 cycles later.
- Enable gating: en toggles 1,0,1,0 during RUN -> out decrements only on en=1 cycles; tc arrives after 10 enabled cycles.
- Load behaviour:
  - load_val=3 during RUN at out=7 -> out=3 next edge, no tc, state stays RUN, tc 4 enabled cycles later.
  - load_val=15 -> out=9 (saturated).
  - load+start together in IDLE -> IDLE, out=load value.
- Load in DONE: after a one-shot expiry, load_val=5 -> state IDLE, done=0, out=5. en=1 without start -> out holds at 5.
